// File: rtl/ram_adapter_pkg.sv
// Shared types and helpers for the RAM port adapter: access sizes,
// byte-lane mask generation and load-data alignment/extension.
package ram_adapter_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } mem_size_t;

   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] mask;
      case (size)
         SIZE_B:  mask = 4'b0001 << offset;
         SIZE_H:  mask = 4'b0011 << offset;
         SIZE_W:  mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // Shift the addressed lane down to bit 0, then extend to the full word.
   function automatic logic [31:0] load_format(input logic [31:0] data, input logic [1:0] size,
                                               input logic [1:0] offset, input logic sign_ext);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = data >> {offset, 3'b000};
      case (size)
         SIZE_B:  result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         SIZE_H:  result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         SIZE_W:  result = shifted;
         default: result = '0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/ram_port_adapter_skid.sv
// Two-entry fall-through response buffer; an empty buffer passes its input
// straight through so a response is not delayed when nothing is queued.
module ram_rsp_skid #(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count_next
);

   logic [WIDTH-1:0] mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   always_comb begin
      pop        = (count != 2'd0) && out_ready;
      push       = in_valid && !((count == 2'd0) && out_ready);
      out_valid  = (count != 2'd0) || in_valid;
      out_data   = (count == 2'd0) ? in_data : mem[rd_ptr];
      count_next = count + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         count <= count_next;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/ram_port_adapter.sv
// Load/store request front end for one port of a 32-bit byte-enable RAM.
// Define RAM_ADAPTER_SKID_EN for a 2-entry response buffer and registered req_ready.
module ram_port_adapter
   import ram_adapter_pkg::*;
#(
   parameter int          RAM_DEPTH = 16384,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [31:0]                  req_addr,
   input  logic                         req_we,
   input  logic [1:0]                   req_size,
   input  logic                         req_signed,
   input  logic [31:0]                  req_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [31:0]                  rsp_rdata,
   output logic                         rsp_error,
   output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
   output logic [31:0]                  ram_din,
   output logic                         ram_en,
   output logic [3:0]                   ram_we,
   input  logic [31:0]                  ram_dout
);

   localparam int          AW   = $clog2(RAM_DEPTH);
   localparam logic [32:0] SPAN = 33'(RAM_DEPTH) * 33'd4;

   logic        accept;
   logic        legal;
   logic        aligned;
   logic        in_range;
   logic [31:0] offset_addr;
   logic        st_valid;
   logic        st_valid_next;
   logic [1:0]  st_size;
   logic        st_sign;
   logic [1:0]  st_off;
   logic        st_we;
   logic        st_err;
   logic [31:0] load_data;

   // An address below BASE_ADDR wraps to a large offset, so one compare covers both bounds.
   always_comb begin
      offset_addr = req_addr - BASE_ADDR;
      in_range    = ({1'b0, offset_addr} < SPAN);
      case (req_size)
         SIZE_B:  aligned = 1'b1;
         SIZE_H:  aligned = !req_addr[0];
         SIZE_W:  aligned = (req_addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
      legal    = aligned && in_range;
      accept   = req_valid && req_ready;
      ram_en   = accept && legal && reset_n;
      ram_we   = (ram_en && req_we) ? byte_mask(req_size, req_addr[1:0]) : 4'b0000;
      ram_addr = offset_addr[AW+1:2];
      case (req_size)
         SIZE_B:  ram_din = {4{req_wdata[7:0]}};
         SIZE_H:  ram_din = {2{req_wdata[15:0]}};
         default: ram_din = req_wdata;
      endcase
   end

   always_comb begin
`ifdef RAM_ADAPTER_SKID_EN
      st_valid_next = accept;
`else
      st_valid_next = accept ? 1'b1 : (rsp_ready ? 1'b0 : st_valid);
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_valid <= 1'b0;
         st_size  <= 2'b00;
         st_sign  <= 1'b0;
         st_off   <= 2'b00;
         st_we    <= 1'b0;
         st_err   <= 1'b0;
      end else begin
         st_valid <= st_valid_next;
         if (accept) begin
            st_size <= req_size;
            st_sign <= req_signed;
            st_off  <= req_addr[1:0];
            st_we   <= req_we;
            st_err  <= !legal;
         end
      end
   end

   always_comb begin
      load_data = (st_valid && !st_we && !st_err) ? load_format(ram_dout, st_size, st_off, st_sign) : 32'h0;
   end

`ifdef RAM_ADAPTER_SKID_EN
   logic [1:0]  skid_count_next;
   logic [32:0] skid_out;
   logic        skid_valid;
   logic        ready_q;

   ram_rsp_skid #(.WIDTH(33)) u_skid (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (st_valid),
      .in_data    ({load_data, st_valid && st_err}),
      .out_valid  (skid_valid),
      .out_ready  (rsp_ready),
      .out_data   (skid_out),
      .count_next (skid_count_next)
   );

   // Leave room for whatever is queued plus the response still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ready_q <= 1'b1;
      else          ready_q <= ({1'b0, skid_count_next} + {2'b00, accept}) <= 3'd1;
   end

   always_comb begin
      req_ready = ready_q;
      rsp_valid = skid_valid;
      rsp_rdata = skid_valid ? skid_out[32:1] : 32'h0;
      rsp_error = skid_valid && skid_out[0];
   end
`else
   always_comb begin
      req_ready = !st_valid || rsp_ready;
      rsp_valid = st_valid;
      rsp_rdata = load_data;
      rsp_error = st_valid && st_err;
   end
`endif

endmodule

// File: tb/tb_ram_port_adapter.sv
// Self-checking bench for ram_port_adapter: vector table plus hand-written
// stall and reset sequences, with a response scoreboard and a RAM model.
module tb_ram_port_adapter;

   localparam int DEPTH = 16384;
   localparam int AW    = $clog2(DEPTH);

   logic             clk        = 1'b0;
   logic             reset_n    = 1'b0;
   logic             req_valid  = 1'b0;
   logic             req_we     = 1'b0;
   logic             req_signed = 1'b0;
   logic             rsp_ready  = 1'b1;
   logic [31:0]      req_addr   = 32'h0;
   logic [31:0]      req_wdata  = 32'h0;
   logic [1:0]       req_size   = 2'b00;
   logic             req_ready;
   logic             rsp_valid;
   logic             rsp_error;
   logic             ram_en;
   logic [31:0]      rsp_rdata;
   logic [31:0]      ram_din;
   logic [31:0]      ram_dout   = 32'h0;
   logic [AW-1:0]    ram_addr;
   logic [3:0]       ram_we;
   logic [31:0]      mem [DEPTH];
   logic [31:0]      ram_word;
   int               checks     = 0;
   int               errors     = 0;
   logic             lat_pending = 1'b0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] wdata;
      logic        exp_en;
      logic [3:0]  exp_we;
      logic [31:0] exp_din;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q [$];
   rsp_t got;
   vec_t vecs  [$];

   ram_port_adapter #(.RAM_DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_error  (rsp_error),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_dout   (ram_dout)
   );

   always #5 clk = ~clk;

   // Write-first byte-enable RAM with a registered read port.
   always @(posedge clk) begin
      if (ram_en) begin
         ram_word = mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_word[b*8 +: 8] = ram_din[b*8 +: 8];
         mem[ram_addr] <= ram_word;
         ram_dout      <= ram_word;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] wdata, input logic en,
                               input logic [3:0] mwe, input logic [31:0] din,
                               input logic [31:0] rdata, input logic err);
      vec_t v;
      v.addr = addr; v.we = we; v.size = size; v.sgn = sgn; v.wdata = wdata;
      v.exp_en = en; v.exp_we = mwe; v.exp_din = din; v.exp_rdata = rdata; v.exp_err = err;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      int   waited;
      rsp_t r;
      req_valid  = 1'b1;
      req_addr   = v.addr;
      req_we     = v.we;
      req_size   = v.size;
      req_signed = v.sgn;
      req_wdata  = v.wdata;
      waited     = 0;
      @(negedge clk);
      while (!req_ready && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      if (!req_ready) begin
         checkOutput("accept_timeout", {31'b0, req_ready}, 32'h1);
      end else begin
         checkOutput("ram_en", {31'b0, ram_en}, {31'b0, v.exp_en});
         checkOutput("ram_we", {28'b0, ram_we}, {28'b0, v.exp_we});
         if (v.exp_en) checkOutput("ram_addr", 32'(ram_addr), 32'(v.addr[AW+1:2]));
         if (v.we && v.exp_en) checkOutput("ram_din", ram_din, v.exp_din);
         r.rdata = v.exp_rdata;
         r.err   = v.exp_err;
         exp_q.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checkOutput("drain_empty", 32'(exp_q.size()), 32'h0);
      @(negedge clk);
      checkOutput("idle_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: a response is consumed on the edge after this sample point.
   always @(negedge clk) begin
      if (!reset_n) begin
         lat_pending = 1'b0;
      end else begin
         if (lat_pending) checkOutput("rsp_latency", {31'b0, rsp_valid}, 32'h1);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
            end else begin
               got = exp_q.pop_front();
               checkOutput("rsp_rdata", rsp_rdata, got.rdata);
               checkOutput("rsp_error", {31'b0, rsp_error}, {31'b0, got.err});
            end
         end
         lat_pending = req_valid && req_ready;
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
      req_addr  = 32'h10; req_wdata = 32'h5555_5555;
      repeat (2) @(negedge clk);
      checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h1);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("reset_rsp_error", {31'b0, rsp_error}, 32'h0);
      checkOutput("reset_ram_en", {31'b0, ram_en}, 32'h0);
      checkOutput("reset_ram_we", {28'b0, ram_we}, 32'h0);
      req_valid = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      vecs.push_back(mk(32'h10,    1, 2'b10, 0, 32'hDEAD_BEEF, 1, 4'hF, 32'hDEAD_BEEF, 32'h0,         0));
      vecs.push_back(mk(32'h10,    0, 2'b10, 0, 32'h0,         1, 4'h0, 32'h0,         32'hDEAD_BEEF, 0));
      vecs.push_back(mk(32'h13,    1, 2'b00, 0, 32'h0000_0080, 1, 4'h8, 32'h8080_8080, 32'h0,         0));
      vecs.push_back(mk(32'h13,    0, 2'b00, 1, 32'h0,         1, 4'h0, 32'h0,         32'hFFFF_FF80, 0));
      vecs.push_back(mk(32'h13,    0, 2'b00, 0, 32'h0,         1, 4'h0, 32'h0,         32'h0000_0080, 0));
      vecs.push_back(mk(32'h11,    0, 2'b01, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0,         1));
      vecs.push_back(mk(32'h10000, 0, 2'b10, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0,         1));
      vecs.push_back(mk(32'h20,    1, 2'b10, 0, 32'h1234_5678, 1, 4'hF, 32'h1234_5678, 32'h0,         0));
      vecs.push_back(mk(32'h20,    0, 2'b10, 0, 32'h0,         1, 4'h0, 32'h0,         32'h1234_5678, 0));
      vecs.push_back(mk(32'h20,    0, 2'b11, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0,         1));
      vecs.push_back(mk(32'h12,    0, 2'b01, 1, 32'h0,         1, 4'h0, 32'h0,         32'hFFFF_80AD, 0));
      vecs.push_back(mk(32'h16,    1, 2'b01, 0, 32'h0000_ABCD, 1, 4'hC, 32'hABCD_ABCD, 32'h0,         0));
      vecs.push_back(mk(32'h16,    0, 2'b01, 0, 32'h0,         1, 4'h0, 32'h0,         32'h0000_ABCD, 0));
      vecs.push_back(mk(32'h14,    0, 2'b10, 0, 32'h0,         1, 4'h0, 32'h0,         32'hABCD_0000, 0));
      vecs.push_back(mk(32'hFFFC,  0, 2'b10, 0, 32'h0,         1, 4'h0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(32'h11,    0, 2'b00, 0, 32'h0,         1, 4'h0, 32'h0,         32'h0000_00BE, 0));
      vecs.push_back(mk(32'h10004, 1, 2'b10, 0, 32'h1111_1111, 0, 4'h0, 32'h0,         32'h0,         1));
      vecs.push_back(mk(32'h22,    1, 2'b10, 0, 32'h2222_2222, 0, 4'h0, 32'h0,         32'h0,         1));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(32'h40 + 32'(i*4), 1, 2'b10, 0, 32'hA000_0000 + 32'(i), 1, 4'hF,
                           32'hA000_0000 + 32'(i), 32'h0, 0));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(32'h40 + 32'(i*4), 0, 2'b10, 0, 32'h0, 1, 4'h0, 32'h0,
                           32'hA000_0000 + 32'(i), 0));

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
      drain();

      // Backpressure: response held while rsp_ready is low.
      rsp_ready = 1'b0;
      applyStimulus(mk(32'h40, 0, 2'b10, 0, 32'h0, 1, 4'h0, 32'h0, 32'hA000_0000, 0));
      req_valid = 1'b1; req_addr = 32'h44; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("stall_rsp_valid", {31'b0, rsp_valid}, 32'h1);
         checkOutput("stall_rsp_rdata", rsp_rdata, 32'hA000_0000);
`ifdef RAM_ADAPTER_SKID_EN
         if (k == 0) begin
            checkOutput("skid_accept_en", {31'b0, ram_en}, 32'h1);
            got.rdata = 32'hA000_0001;
            got.err   = 1'b0;
            exp_q.push_back(got);
         end else begin
            checkOutput("stall_req_ready", {31'b0, req_ready}, 32'h0);
            checkOutput("stall_ram_en", {31'b0, ram_en}, 32'h0);
         end
`else
         checkOutput("stall_req_ready", {31'b0, req_ready}, 32'h0);
         checkOutput("stall_ram_en", {31'b0, ram_en}, 32'h0);
`endif
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
`ifdef RAM_ADAPTER_SKID_EN
      req_valid = 1'b0;
`else
      applyStimulus(mk(32'h44, 0, 2'b10, 0, 32'h0, 1, 4'h0, 32'h0, 32'hA000_0001, 0));
`endif
      drain();

      // Reset while a store response is pending; the store itself must persist.
      rsp_ready = 1'b0;
      applyStimulus(mk(32'h60, 1, 2'b10, 0, 32'hCAFE_F00D, 1, 4'hF, 32'hCAFE_F00D, 32'h0, 0));
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      checkOutput("async_req_ready", {31'b0, req_ready}, 32'h1);
      exp_q.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      rsp_ready = 1'b1;
      applyStimulus(mk(32'h60, 0, 2'b10, 0, 32'h0, 1, 4'h0, 32'h0, 32'hCAFE_F00D, 0));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
